demux1to4_buf: RTL

Registered 1-to-4 demultiplexer with valid/ready handshake: the write-side counterpart of the 4-to-1 read mux used on datapath select points. One input word plus a 2-bit select is steered into one of four single-entry output buffers, each drained independently by its own consumer. It sits between a single producer, such as a writeback or result bus, and four destination ports or units.

---
 rtl/demux1to4_buf.sv | 79 +++++++
 1 files changed

// File: rtl/demux1to4_buf.sv
// rtl/demux1to4_buf.sv - registered 1-to-4 demux into single-entry buffers; optional DEMUX1TO4_STAT_EN accept counter
module demux1to4_buf #(
    parameter int bit_size = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [bit_size-1:0] in_data,
    input  logic [1:0]          in_sel,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [bit_size-1:0] out0,
    output logic [bit_size-1:0] out1,
    output logic [bit_size-1:0] out2,
    output logic [bit_size-1:0] out3,
    output logic [15:0]         stat_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t           ch_state [4];
    logic [bit_size-1:0] ch_data  [4];
    logic                acc;

    // A full channel can still take a word if its consumer drains it this cycle.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    assign acc      = in_valid & in_ready;

    always_comb begin
        out_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            out_valid[k] = (ch_state[k] == FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                ch_state[k] <= EMPTY;
                ch_data[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acc && (in_sel == 2'(k))) begin
                    ch_state[k] <= FULL;
                    ch_data[k]  <= in_data;
                end else if (out_valid[k] && out_ready[k]) begin
                    ch_state[k] <= EMPTY;
                end
            end
        end
    end

    assign out0 = ch_data[0];
    assign out1 = ch_data[1];
    assign out2 = ch_data[2];
    assign out3 = ch_data[3];

`ifdef DEMUX1TO4_STAT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'h0000;
        end else if (acc) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign stat_cnt = cnt_q;
`else
    assign stat_cnt = 16'h0000;
`endif

endmodule
